shift_serializer: RTL and testbench

Parametrised parallel-to-serial shifter, the successor to the fixed 8-bit load/shift register. It accepts a WIDTH-bit word through a valid/ready load handshake. It then emits the word one bit per enable strobe, LSB-first or MSB-first, and tracks the bit count itself. It flags the last bit and pulses done on completion, so upstream control no longer has to count shifts. It sits between the word-level datapath and a bit-serial transmitter, which drives enable as its bit strobe.

---
 rtl/shift_serializer_pkg.sv | 16 +
 rtl/shift_serializer_if.sv | 41 ++++
 rtl/shift_bit_counter.sv | 31 +++
 rtl/shift_serializer.sv | 125 ++++++++++++
 tb/tb_shift_serializer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/shift_serializer_pkg.sv
// shift_serializer_pkg: FSM state type and counter-width helper
// shared by the serializer top, its bit counter and the bench.
package shift_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY
  } state_t;

  // Counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// shift_serializer_if: load handshake (load_valid/ready/data), bit
// strobe (enable) and serial side (ser_out/valid/last, busy, done).
interface shift_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             enable;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output enable,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_last,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  enable,
    output load_ready,
    output ser_out,
    output ser_valid,
    output ser_last,
    output busy,
    output done
  );

endinterface

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: loadable down-counter of remaining data bits.
// Ports: clk, rst, load (set to WIDTH), dec (count-1), is_one.
module shift_bit_counter
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic is_one
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH);
    end else if (dec) begin
      count <= count - CW'(1);
    end
  end

  assign is_one = (count == CW'(1));

endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: WIDTH-bit parallel-to-serial shifter, LSB/MSB first.
// Ports: clk, rst, bus (slave); SHIFT_SERIALIZER_PARITY_EN adds parity bit.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit ODD_PARITY = 1'b0
) (
  input logic              clk,
  input logic              rst,
  shift_serializer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             head;
  logic             done_q;
  logic             cnt_one;
  logic             accept;
  logic             consume;
  logic             so;

  assign accept  = bus.load_valid & (state == ST_IDLE);
  assign consume = bus.enable & (state == ST_SHIFT);

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .dec    (consume),
    .is_one (cnt_one)
  );

  // Shift direction: head bit is the one on the wire,
  // zero fill enters from the opposite end.
  generate
    if (MSB_FIRST) begin : g_msb
      assign head      = shreg[WIDTH-1];
      assign shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign head      = shreg[0];
      assign shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= (^bus.load_data) ^ ODD_PARITY;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.load_valid) begin
            shreg <= bus.load_data;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.enable) begin
            shreg <= shreg_nxt;
            if (cnt_one) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
              state  <= ST_PARITY;
`else
              state  <= ST_IDLE;
              done_q <= 1'b1;
`endif
            end
          end
        end
`ifdef SHIFT_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (bus.enable) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    so = 1'b0;
    unique case (1'b1)
      (state == ST_SHIFT):  so = head;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      (state == ST_PARITY): so = par_q;
`endif
      default:              so = 1'b0;
    endcase
  end

  assign bus.ser_out    = so;
  assign bus.load_ready = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.ser_valid  = (state != ST_IDLE);
  assign bus.done       = done_q;

`ifdef SHIFT_SERIALIZER_PARITY_EN
  assign bus.ser_last = (state == ST_PARITY);
`else
  assign bus.ser_last = (state == ST_SHIFT) & cnt_one;
`endif

endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: three serializer instances (8 LSB, 8 MSB, 12 LSB)
// checked per cycle against a bit-list model of each frame.
module tb_shift_serializer;

  localparam bit ODD = 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  lv  = '0;
  logic [2:0]  en  = '0;
  logic [11:0] ld  = '0;

  int total = 0;
  int bad   = 0;

  shift_serializer_if #(.WIDTH(8))  if0 ();
  shift_serializer_if #(.WIDTH(8))  if1 ();
  shift_serializer_if #(.WIDTH(12)) if2 ();

  assign if0.load_valid = lv[0];
  assign if0.load_data  = ld[7:0];
  assign if0.enable     = en[0];
  assign if1.load_valid = lv[1];
  assign if1.load_data  = ld[7:0];
  assign if1.enable     = en[1];
  assign if2.load_valid = lv[2];
  assign if2.load_data  = ld;
  assign if2.enable     = en[2];

  wire [2:0] so  = {if2.ser_out,    if1.ser_out,    if0.ser_out};
  wire [2:0] sv  = {if2.ser_valid,  if1.ser_valid,  if0.ser_valid};
  wire [2:0] sl  = {if2.ser_last,   if1.ser_last,   if0.ser_last};
  wire [2:0] bz  = {if2.busy,       if1.busy,       if0.busy};
  wire [2:0] dn  = {if2.done,       if1.done,       if0.done};
  wire [2:0] rdy = {if2.load_ready, if1.load_ready, if0.load_ready};

  shift_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .ODD_PARITY(ODD)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  shift_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .ODD_PARITY(ODD)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  shift_serializer #(
    .WIDTH(12), .MSB_FIRST(1'b0), .ODD_PARITY(ODD)
  ) u2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  function automatic int wof(input int k);
    return (k == 2) ? 12 : 8;
  endfunction

  function automatic bit mof(input int k);
    return (k == 1);
  endfunction

  function automatic logic [11:0] mask(input int k);
    return (k == 2) ? 12'hFFF : 12'h0FF;
  endfunction

  // Frame bit i of word w on instance k: data bits in wire order,
  // then the parity bit when the feature is built in.
  function automatic logic exp_bit(input logic [11:0] w,
                                   input int k, input int i);
    int wd;
    wd = wof(k);
    if (i == wd) return (^w) ^ ODD;
    if (mof(k)) return w[wd-1-i];
    return w[i];
  endfunction

  task automatic chk(input string tag, input logic obs,
                     input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input int k);
    chk("rst_ready", rdy[k], 1'b1);
    chk("rst_valid", sv[k],  1'b0);
    chk("rst_busy",  bz[k],  1'b0);
    chk("rst_done",  dn[k],  1'b0);
    chk("rst_out",   so[k],  1'b0);
    chk("rst_last",  sl[k],  1'b0);
  endtask

  task automatic start(input int k, input logic [11:0] w);
    chk("ready_idle", rdy[k], 1'b1);
    lv[k] = 1'b1;
    ld    = w;
    @(negedge clk);
    lv[k] = 1'b0;
  endtask

  // mode 0: enable always; 1: pattern 1,0,0; 2: random stalls.
  task automatic stream(input int k, input logic [11:0] w,
                        input int mode, input bit hold_next,
                        input logic [11:0] nw);
    int n;
    int i;
    int c;
    int cyc;
    bit e;
    n   = wof(k) + PAR;
    i   = 0;
    c   = 0;
    cyc = 0;
    if (hold_next) begin
      lv[k] = 1'b1;
      ld    = nw;
    end
    while (i < n) begin
      chk("valid",     sv[k],  1'b1);
      chk("bit",       so[k],  exp_bit(w, k, i));
      chk("last",      sl[k],  (i == n - 1));
      chk("busy",      bz[k],  1'b1);
      chk("not_ready", rdy[k], 1'b0);
      chk("no_done",   dn[k],  1'b0);
      case (mode)
        0:       e = 1'b1;
        1:       e = ((c % 3) == 0);
        default: e = 1'($urandom_range(0, 1));
      endcase
      c++;
      en[k] = e;
      @(negedge clk);
      if (e) i++;
      cyc++;
      if (cyc > 400) begin
        total++;
        bad++;
        $error("FAIL budget observed=%0d bits expected=%0d", i, n);
        break;
      end
    end
    en[k] = 1'b0;
    chk("done",       dn[k],  1'b1);
    chk("ready_done", rdy[k], 1'b1);
    chk("idle_valid", sv[k],  1'b0);
    chk("idle_busy",  bz[k],  1'b0);
    @(negedge clk);
    if (hold_next) begin
      lv[k] = 1'b0;
    end else begin
      chk("done_once", dn[k], 1'b0);
      chk("idle_out",  so[k], 1'b0);
    end
  endtask

  initial begin
    int k;
    logic [11:0] w;
    @(negedge clk);
    for (int j = 0; j < 3; j++) check_reset(j);
    rst = 1'b0;
    @(negedge clk);

    en = 3'b111;
    @(negedge clk);
    chk("idle_en_valid", sv[0],  1'b0);
    chk("idle_en_ready", rdy[0], 1'b1);
    chk("idle_en_done",  dn[0],  1'b0);
    en = 3'b000;

    start(0, 12'h0B4);
    stream(0, 12'h0B4, 0, 1'b0, 12'h0);
    start(1, 12'h0B4);
    stream(1, 12'h0B4, 0, 1'b0, 12'h0);
    start(2, 12'h801);
    stream(2, 12'h801, 0, 1'b0, 12'h0);

    start(0, 12'h0B4);
    stream(0, 12'h0B4, 1, 1'b0, 12'h0);

    start(0, 12'h0B4);
    stream(0, 12'h0B4, 0, 1'b1, 12'h00F);
    stream(0, 12'h00F, 0, 1'b0, 12'h0);

    start(0, 12'h0B4);
    en[0] = 1'b1;
    repeat (3) @(negedge clk);
    en[0] = 1'b0;
    chk("pre_rst_valid", sv[0], 1'b1);
    #2 rst = 1'b1;
    #1 check_reset(0);
    @(negedge clk);
    chk("rst_no_done", dn[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_reset(0);
    start(0, 12'h0FF);
    stream(0, 12'h0FF, 0, 1'b0, 12'h0);

    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 2);
      w = 12'($urandom) & mask(k);
      start(k, w);
      stream(k, w, $urandom_range(0, 2), 1'b0, 12'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
